pwconv_scheduler: RTL
=====================

// Module: pwconv_scheduler
// PURPOSE
//  Sequences one pointwise-conv layer: drives the (cnt, pos) stream and enable for the PWconv data
//  controller, and issues feature-buffer prefetch reads so the next position's channel vector is
//  stable when the controller latches it at cnt==N_CH-1. Start/busy/done handshake toward the layer
//  sequencer; stall input gives downstream backpressure (PE array / output writer).
// PARAMETERS
//  N_CH    32  output-channel iterations per position (cnt range 0..N_CH-1)
//  N_POS   16  spatial positions per layer (pos range 0..N_POS-1)
//  CNT_W   5   width of cnt, $clog2(N_CH)
//  POS_W   4   width of pos, $clog2(N_POS)
//  RD_LAT  1   feature-buffer read latency in cycles; legal range 1..N_CH-2
// PORTS
//  clk        in   1      clock
//  rst_b      in   1      asynchronous active-low reset
//  start      in   1      single-cycle layer start; ignored unless state==IDLE
//  abort      in   1      synchronous abort; any state -> IDLE next cycle, no done
//  stall      in   1      downstream not ready; freezes sequencing while high
//  busy       out  1      high in every state except IDLE
//  done       out  1      one-cycle pulse after final compute cycle
//  en         out  1      data-controller enable / PE compute strobe
//  cnt        out  CNT_W  channel counter to data controller cnt_in
//  pos        out  POS_W  position being LOADED (to data controller pos_in)
//  comp_pos   out  POS_W  position currently being COMPUTED (for output-address generation)
//  rd_req     out  1      feature-buffer read strobe, one pulse per position
//  rd_pos     out  POS_W  feature-buffer read address, valid with rd_req
//  first_ch   out  1      en && cnt==0 (accumulator clear)
//  last_ch    out  1      en && cnt==N_CH-1 (result write)
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; internal counters 0.
//  FSM: IDLE -> FETCH (on start) -> LOAD -> RUN -> DONE -> IDLE.
//   IDLE : en=0. start: rd_req=1, rd_pos=0 same cycle (combinational), go FETCH, wait counter=RD_LAT.
//   FETCH: en=0; decrement wait counter; at 0 -> LOAD. Stall ignored (no downstream activity).
//   LOAD : cnt=N_CH-1, pos=0, en=!stall -> controller latches pos 0. On en: -> RUN, cnt=0,
//          comp_pos=0, pos=1 (mod N_POS). Stalled: hold.
//   RUN  : en=!stall. Each enabled cycle cnt++; at cnt==N_CH-1 cnt wraps to 0, comp_pos++,
//          pos++ (mod N_POS). Enabled cycle with cnt==N_CH-1 && comp_pos==N_POS-1 -> DONE.
//   DONE : en=0, done=1 for exactly one cycle, -> IDLE.
//  Prefetch: rd_req=1, rd_pos=pos when en && cnt==N_CH-1-RD_LAT && comp_pos!=N_POS-1.
//   Exactly one pulse per position even if stall is held at that cnt (gated by en).
//   Buffer holds read data until next rd_req; stalls between rd_req and latch are safe.
//  Stall: while high in LOAD/RUN, en=0, cnt/pos/comp_pos hold, rd_req/first_ch/last_ch=0.
//  On the final position pos wraps to 0; the controller's last latch is don't-care (no rd_req).
//  Latency: start -> first en = RD_LAT+1 cycles; unstalled total start->done = RD_LAT+2+N_POS*N_CH
//   (defaults: 515 cycles).
//  abort has priority over start/stall in same cycle; start in same cycle as abort ignored.
//  start while busy: ignored, no effect on counters. start in DONE cycle: ignored.
//  Counters: cnt compares against N_CH-1 explicitly (N_CH need not be a power of two); pos and
//   comp_pos wrap at N_POS explicitly.
// STRUCTURE
//  Shared pkg pwconv_pkg: N_CH, N_POS, CNT_W, POS_W, RD_LAT defaults; FSM state localparams
//   (IDLE, FETCH, LOAD, RUN, DONE, 3-bit encoded).
//  One sub-module: pwconv_pos_counter (cnt/pos/comp_pos wrap counters with enable, load, clear);
//   FSM, prefetch decode and handshake stay in the top.
// TESTING
//  1 Default params, start once, stall=0 -> first en at cycle 2; done at cycle 515; 16 rd_req
//    pulses, rd_pos=0..15 (one per position); pos sequence 0,1..15,0.
//  2 Stall high 5 cycles at RUN cnt=10, comp_pos=3 -> en=0, cnt=10/pos=4 held; resumes cnt=11;
//    done delayed exactly 5 cycles.
//  3 Stall held 3 cycles at cnt=30 (N_CH-1-RD_LAT) -> rd_req pulses once only, rd_pos=comp_pos+1.
//  4 start pulsed during RUN and in DONE cycle -> no restart, counters undisturbed, single done.
//  5 abort at comp_pos=7, cnt=20 -> IDLE next cycle, no done, busy=0; new start runs full 515 cycles.
//  6 rst_b low mid-RUN -> all outputs 0 immediately; after release, start -> nominal run.

Source files
------------

// File: rtl/pwconv_pkg.sv
// rtl/pwconv_pkg.sv - shared defaults and FSM state encoding for the pointwise-conv scheduler
package pwconv_pkg;

   localparam int DEF_N_CH   = 32;
   localparam int DEF_N_POS  = 16;
   localparam int DEF_CNT_W  = 5;
   localparam int DEF_POS_W  = 4;
   localparam int DEF_RD_LAT = 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      RUN   = 3'd3,
      DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/pwconv_pos_counter.sv
// rtl/pwconv_pos_counter.sv - channel / load-position / compute-position wrap counters
module pwconv_pos_counter
   import pwconv_pkg::*;
#(
   parameter int N_CH  = DEF_N_CH,
   parameter int N_POS = DEF_N_POS,
   parameter int CNT_W = DEF_CNT_W,
   parameter int POS_W = DEF_POS_W
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             step_comp_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic [POS_W-1:0] pos_o,
   output logic [POS_W-1:0] comp_pos_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_CH - 1);
   localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_POS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [POS_W-1:0] comp_q, comp_d;

   // Clear beats load beats step; pos moves on every channel wrap, comp_pos only when asked
   always_comb begin
      cnt_d  = cnt_q;
      pos_d  = pos_q;
      comp_d = comp_q;
      if (clr_i) begin
         cnt_d  = '0;
         pos_d  = '0;
         comp_d = '0;
      end else if (load_i) begin
         cnt_d  = CNT_MAX;
         pos_d  = '0;
         comp_d = '0;
      end else if (step_i) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            pos_d = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
            if (step_comp_i) begin
               comp_d = (comp_q == POS_MAX) ? '0 : comp_q + 1'b1;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt_q  <= '0;
         pos_q  <= '0;
         comp_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         pos_q  <= pos_d;
         comp_q <= comp_d;
      end
   end

   assign cnt_o      = cnt_q;
   assign pos_o      = pos_q;
   assign comp_pos_o = comp_q;

endmodule

// File: rtl/pwconv_scheduler.sv
// rtl/pwconv_scheduler.sv - pointwise-conv layer sequencer with feature-buffer prefetch
module pwconv_scheduler
   import pwconv_pkg::*;
#(
   parameter int N_CH   = DEF_N_CH,
   parameter int N_POS  = DEF_N_POS,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int POS_W  = DEF_POS_W,
   parameter int RD_LAT = DEF_RD_LAT
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             start,
   input  logic             abort,
   input  logic             stall,
   output logic             busy,
   output logic             done,
   output logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic [POS_W-1:0] pos,
   output logic [POS_W-1:0] comp_pos,
   output logic             rd_req,
   output logic [POS_W-1:0] rd_pos,
   output logic             first_ch,
   output logic             last_ch
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_CH - 1);
   localparam logic [CNT_W-1:0] CNT_PF  = CNT_W'(N_CH - 1 - RD_LAT);
   localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_POS - 1);

   state_e           state_q;
   logic [CNT_W-1:0] wait_q;
   logic             busy_q;
   logic             done_q;
   logic             start_ok;
   logic             fetch_done;
   logic             last_step;
   logic             prefetch;

   // Enable, prefetch strobe and channel markers; abort masks everything in its cycle
   always_comb begin
      start_ok   = (state_q == IDLE) && start && !abort;
      en         = ((state_q == LOAD) || (state_q == RUN)) && !stall && !abort;
      fetch_done = (state_q == FETCH) && (wait_q == CNT_W'(1)) && !abort;
      last_step  = en && (state_q == RUN) && (cnt == CNT_MAX) && (comp_pos == POS_MAX);
      // The last position has no successor to fetch
      prefetch   = en && (cnt == CNT_PF) && (comp_pos != POS_MAX);
      rd_req     = start_ok || prefetch;
      rd_pos     = prefetch ? pos : '0;
      first_ch   = en && (cnt == '0);
      last_ch    = en && (cnt == CNT_MAX);
   end

   // Counters clear on abort and on the final compute step so IDLE always sees zeros
   pwconv_pos_counter #(
      .N_CH  (N_CH),
      .N_POS (N_POS),
      .CNT_W (CNT_W),
      .POS_W (POS_W)
   ) u_pos_counter (
      .clk         (clk),
      .rst_b       (rst_b),
      .clr_i       (abort || last_step),
      .load_i      (fetch_done),
      .step_i      (en),
      .step_comp_i (state_q == RUN),
      .cnt_o       (cnt),
      .pos_o       (pos),
      .comp_pos_o  (comp_pos)
   );

   // Layer FSM with registered busy/done handshake
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= IDLE;
         wait_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort) begin
            state_q <= IDLE;
            wait_q  <= '0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     state_q <= FETCH;
                     wait_q  <= CNT_W'(RD_LAT);
                     busy_q  <= 1'b1;
                  end
               end
               FETCH: begin
                  wait_q <= wait_q - 1'b1;
                  if (wait_q == CNT_W'(1)) begin
                     state_q <= LOAD;
                  end
               end
               LOAD: begin
                  if (!stall) begin
                     state_q <= RUN;
                  end
               end
               RUN: begin
                  if (last_step) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
               DONE: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;

endmodule
